// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and parity mode.
// Parity mode follows UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DATA_W = 8;

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_BREAK   = 3'd5,
    ST_CLEANUP = 3'd6
  } uart_state_e;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_par_err(input logic [DATA_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte with status strobes out.
interface uart_rx_if;
  import uart_pkg::*;

  logic              i_RX_Serial;
  logic              o_RX_DV;
  logic [DATA_W-1:0] o_RX_Byte;
  logic              o_RX_Active;
  logic              o_RX_Frame_Err;
  logic              o_RX_Parity_Err;

  modport slave (
    input  i_RX_Serial,
    output o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err, o_RX_Parity_Err
  );

  modport master (
    output i_RX_Serial,
    input  o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err, o_RX_Parity_Err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RST_VAL.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 or 8E1 (UART_RX_PARITY_EN), mid-bit sampling, one-cycle DV/error strobes.
// No back-pressure: strobes appear the cycle after the stop sample; the byte holds until the next good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic     i_Clock,
  input  logic     i_Rst_L,
  uart_rx_if.slave rx_if
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (i_Clock),
    .rst_ni (i_Rst_L),
    .d_i    (rx_if.i_RX_Serial),
    .q_o    (rx_s)
  );

  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              active_q, active_d;
  logic              dv_q, dv_d;
  logic              ferr_q, ferr_d;
  logic              cnt_wrap;
`ifdef UART_RX_PARITY_EN
  logic              perr_q, perr_d;
  logic              pmis_q, pmis_d;
`endif

  assign cnt_wrap = (cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    active_d = active_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = 1'b0;
    pmis_d   = pmis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        // The detect cycle counts as the first start-bit cycle, so the start
        // sample lands exactly H cycles after the line is first seen low.
        if (!rx_s) begin
          state_d  = ST_START;
          cnt_d    = CW'(1);
          active_d = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        pmis_d = 1'b0;
`endif
      end
      ST_DATA: begin
        if (cnt_wrap) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          pmis_d  = even_par_err(shift_q, rx_s);
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = pmis_q;
`endif
            state_d = ST_CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        active_d = 1'b0;
        cnt_d    = '0;
        idx_d    = 3'd0;
        state_d  = ST_IDLE;
      end
      default: begin
        active_d = 1'b0;
        cnt_d    = '0;
        idx_d    = 3'd0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= '0;
      byte_q   <= '0;
      active_q <= 1'b0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
      pmis_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      active_q <= active_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
      pmis_q   <= pmis_d;
`endif
    end
  end

  assign rx_if.o_RX_DV         = dv_q;
  assign rx_if.o_RX_Byte       = byte_q;
  assign rx_if.o_RX_Active     = active_q;
  assign rx_if.o_RX_Frame_Err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_RX_Parity_Err = perr_q;
`else
  assign rx_if.o_RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames, scoreboard-checked.
module tb_uart_rx;

  localparam int C = 8;
  localparam int H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int  NB     = 11;
  localparam bit  PAR_ON = 1'b1;
`else
  localparam int  NB     = 10;
  localparam bit  PAR_ON = 1'b0;
`endif

  typedef struct {
    bit         is_dv;
    logic [7:0] byt;
    bit         perr;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   dv_cycles[$];
  logic [7:0] last_good = 8'h00;
  exp_t e;
  logic active_prev = 1'b0;
  int   last_fall = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .rx_if   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected frame outcome.
  always @(negedge clk) begin
    if (rst_n && (bus.o_RX_DV || bus.o_RX_Frame_Err || bus.o_RX_Parity_Err)) begin
      if (bus.o_RX_DV) dv_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_dv", bus.o_RX_DV, e.is_dv);
        check("sb_frame_err", bus.o_RX_Frame_Err, !e.is_dv);
        check("sb_parity_err", bus.o_RX_Parity_Err, e.perr);
        check("sb_byte", bus.o_RX_Byte, e.byt);
        check("sb_cycle", cyc, e.cyc);
      end
    end
    if (active_prev && !bus.o_RX_Active) last_fall = cyc;
    active_prev = bus.o_RX_Active;
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int k);
    bus.i_RX_Serial = 1'b1;
    step(k);
  endtask

  // Drives one frame and records the outcome the receiver must produce.
  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop, output int n);
    logic [11:0] b;
    exp_t x;
    b = '0;
    b[8:1] = data;
    if (PAR_ON) begin
      b[9]  = pbit;
      b[10] = stop;
    end else begin
      b[9] = stop;
    end
    n = cyc;
    x.cyc = n + 3 + H + (NB - 1) * C;
    if (stop) begin
      x.is_dv = 1'b1;
      x.byt   = data;
      x.perr  = PAR_ON && ((^data) ^ pbit);
      last_good = data;
    end else begin
      x.is_dv = 1'b0;
      x.byt   = last_good;
      x.perr  = 1'b0;
    end
    sb.push_back(x);
    for (int i = 0; i < NB; i++) begin
      bus.i_RX_Serial = b[i];
      step(C);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ^d;
  endfunction

  initial begin
    int n;
    int cnt;
    logic [7:0] d;
    logic [7:0] pat;
    logic st;

    bus.i_RX_Serial = 1'b1;
    rst_n = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_dv", bus.o_RX_DV, 0);
    check("rst_byte", bus.o_RX_Byte, 0);
    check("rst_active", bus.o_RX_Active, 0);
    check("rst_frame_err", bus.o_RX_Frame_Err, 0);
    check("rst_parity_err", bus.o_RX_Parity_Err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    // Good frame; Active must drop two cycles after the stop sample.
    send_frame(8'hA5, good_par(8'hA5), 1'b1, n);
    check("a5_active_fall", last_fall, n + 4 + H + (NB - 1) * C);
    idle(4);

    // Short low glitch on an idle line.
    bus.i_RX_Serial = 1'b0;
    step(2);
    bus.i_RX_Serial = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_RX_Active) cnt++;
    end
    check("glitch_active_1to5", (cnt >= 1 && cnt <= 5), 1);
    @(posedge clk);
    #1;
    idle(4);

    // Bad stop bit, then line held low: Active must stay high until release.
    send_frame(8'h3C, good_par(8'h3C), 1'b0, n);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (!bus.o_RX_Active) cnt++;
    end
    check("break_active_held", cnt, 0);
    @(posedge clk);
    #1;
    idle(6);
    check("break_active_released", bus.o_RX_Active, 0);
    check("break_byte_held", bus.o_RX_Byte, 8'hA5);

    // Back-to-back frames with no idle gap.
    dv_cycles.delete();
    send_frame(8'h00, good_par(8'h00), 1'b1, n);
    send_frame(8'hFF, good_par(8'hFF), 1'b1, n);
    idle(8);
    check("b2b_dv_count", dv_cycles.size(), 2);
    if (dv_cycles.size() == 2) check("b2b_spacing", dv_cycles[1] - dv_cycles[0], NB * C);

    // Reset during data bit 4 of a frame.
    pat = 8'h77;
    bus.i_RX_Serial = 1'b0;
    step(C);
    for (int i = 0; i < 4; i++) begin
      bus.i_RX_Serial = pat[i];
      step(C);
    end
    bus.i_RX_Serial = pat[4];
    step(2);
    rst_n = 1'b0;
    bus.i_RX_Serial = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    check("midrst_active", bus.o_RX_Active, 0);
    check("midrst_byte", bus.o_RX_Byte, 0);
    check("midrst_dv", bus.o_RX_DV, 0);
    check("midrst_errs", {bus.o_RX_Frame_Err, bus.o_RX_Parity_Err}, 0);
    @(posedge clk);
    #1;
    step(2);
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h5A, good_par(8'h5A), 1'b1, n);
    idle(3);
    check("post_rst_byte", bus.o_RX_Byte, 8'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b0, 1'b1, n);
    idle(3);
    send_frame(8'h01, 1'b1, 1'b1, n);
    idle(3);
`endif

    // Random frames: arbitrary data/parity, occasional bad stop with a break.
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, 1'($urandom_range(0, 1)), st, n);
      if (!st) begin
        bus.i_RX_Serial = 1'b0;
        step($urandom_range(0, 10));
        idle(4 + $urandom_range(0, 3));
      end else begin
        idle($urandom_range(0, 2));
      end
    end

    idle(20);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
